// File: rtl/argmax_unit_if.sv
// argmax_unit_if: request, score-RAM read port and result bundle for argmax_unit.
// slave is the argmax engine; master is the requester that also owns the score RAM.
interface argmax_unit_if #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 10
);
  localparam int IDX_W = $clog2(NUM_CLASSES);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  category_out;
  logic [DATA_W-1:0] max_score;
  logic [IDX_W-1:0]  second_idx;
  logic [DATA_W:0]   margin;

  modport master (
    output start, base_addr, rd_data,
    input  rd_en, rd_addr, busy, done, category_out, max_score, second_idx, margin
  );

  modport slave (
    input  start, base_addr, rd_data,
    output rd_en, rd_addr, busy, done, category_out, max_score, second_idx, margin
  );
endinterface

// File: rtl/argmax_unit.sv
// argmax_unit: streams NUM_CLASSES scores from the score RAM and reports the
// index and value of the largest one (ties keep the lower index).
// Optional feature: define ARGMAX_MARGIN_EN to add the runner-up index and the
// winner-minus-runner-up margin; without it second_idx and margin are tied to 0.
module argmax_unit #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 8,
  parameter int SIGNED      = 0,
  parameter int ADDR_W      = 10,
  parameter int RD_LATENCY  = 1
) (
  input logic          clk,
  input logic          rst,
  argmax_unit_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W:0]   CMP_TOTAL = (IDX_W + 1)'(NUM_CLASSES);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  iss_cnt;
  logic [IDX_W:0]    cmp_cnt;
  logic              rd_vld_p [RD_LATENCY];
  logic [IDX_W-1:0]  rd_idx_p [RD_LATENCY];
  logic              cmp_vld;
  logic [IDX_W-1:0]  cmp_idx;
  logic              cmp_first;
  logic              new_gt_best;
  logic              take_best;
  logic [DATA_W-1:0] best_val;
  logic [IDX_W-1:0]  best_idx;

  // Score ordering honours the SIGNED parameter.
  function automatic logic score_gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  assign cmp_vld     = rd_vld_p[RD_LATENCY-1];
  assign cmp_idx     = rd_idx_p[RD_LATENCY-1];
  assign cmp_first   = (cmp_idx == '0);
  assign new_gt_best = score_gt(bus.rd_data, best_val);
  assign take_best   = cmp_vld && (cmp_first || new_gt_best);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and read-port outputs; reads are issued straight from the counter.
  always_comb begin
    state_nxt   = state;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    case (state)
      IDLE:  if (bus.start) state_nxt = ISSUE;
      ISSUE: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = base_q + ADDR_W'(iss_cnt);
        if (iss_cnt == LAST_IDX) state_nxt = DRAIN;
      end
      DRAIN: if (cmp_cnt == CMP_TOTAL) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control: counters, busy/done flags and the in-flight read valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_cnt  <= '0;
      cmp_cnt  <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      for (int s = 0; s < RD_LATENCY; s++) rd_vld_p[s] <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        iss_cnt  <= '0;
        cmp_cnt  <= '0;
        bus.busy <= 1'b1;
      end else begin
        if (state == ISSUE) iss_cnt <= iss_cnt + IDX_W'(1);
        if (cmp_vld)        cmp_cnt <= cmp_cnt + (IDX_W + 1)'(1);
        if (state == DONE)  bus.busy <= 1'b0;
      end
      bus.done    <= (state_nxt == DONE);
      rd_vld_p[0] <= (state == ISSUE);
      for (int s = 1; s < RD_LATENCY; s++) rd_vld_p[s] <= rd_vld_p[s-1];
    end
  end

  // Issue stage -> return stage: base capture and class index riding with each read.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) base_q <= bus.base_addr;
    rd_idx_p[0] <= iss_cnt;
    for (int s = 1; s < RD_LATENCY; s++) rd_idx_p[s] <= rd_idx_p[s-1];
  end

  // Compare stage: running best; first element loads unconditionally, later ones need a strict win.
  always_ff @(posedge clk) begin
    if (take_best) begin
      best_val <= bus.rd_data;
      best_idx <= cmp_idx;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  logic              sec_vld;
  logic [DATA_W-1:0] sec_val;
  logic [IDX_W-1:0]  sec_idx;
  logic              demote;
  logic              take_sec;

  // Margin widened by one bit so best - second can never overflow.
  function automatic logic [DATA_W:0] score_diff(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] ax;
    logic signed [DATA_W:0] bx;
    if (SIGNED != 0) begin
      ax = {a[DATA_W-1], a};
      bx = {b[DATA_W-1], b};
    end else begin
      ax = {1'b0, a};
      bx = {1'b0, b};
    end
    return $unsigned(ax - bx);
  endfunction

  assign demote   = cmp_vld && !cmp_first && new_gt_best;
  assign take_sec = cmp_vld && !cmp_first && !new_gt_best &&
                    (!sec_vld || score_gt(bus.rd_data, sec_val));

  // Runner-up validity: invalid after the first element, valid once any later one is seen.
  always_ff @(posedge clk) begin
    if (rst)                       sec_vld <= 1'b0;
    else if (cmp_vld && cmp_first) sec_vld <= 1'b0;
    else if (cmp_vld)              sec_vld <= 1'b1;
  end

  // Runner-up value: takes the displaced best, or a new score beating it (ties with best included).
  always_ff @(posedge clk) begin
    if (demote) begin
      sec_val <= best_val;
      sec_idx <= best_idx;
    end else if (take_sec) begin
      sec_val <= bus.rd_data;
      sec_idx <= cmp_idx;
    end
  end
`endif

  // Result stage: results latched as the FSM enters DONE and held until the next run.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.category_out <= '0;
      bus.max_score    <= '0;
`ifdef ARGMAX_MARGIN_EN
      bus.second_idx   <= '0;
      bus.margin       <= '0;
`endif
    end else if (state_nxt == DONE) begin
      bus.category_out <= best_idx;
      bus.max_score    <= best_val;
`ifdef ARGMAX_MARGIN_EN
      bus.second_idx   <= sec_idx;
      bus.margin       <= score_diff(best_val, sec_val);
`endif
    end
  end

`ifndef ARGMAX_MARGIN_EN
  assign bus.second_idx = '0;
  assign bus.margin     = '0;
`endif
endmodule

// File: tb/tb_argmax_unit.sv
// tb_argmax_unit: two argmax_unit instances (10-class unsigned latency-1, and
// 16-class signed latency-3 with a 4-bit wrapping address) against a queue-based model.
module tb_argmax_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  argmax_unit_if #(.NUM_CLASSES(10), .DATA_W(8), .ADDR_W(10)) ifa();
  argmax_unit_if #(.NUM_CLASSES(16), .DATA_W(8), .ADDR_W(4))  ifb();

  argmax_unit #(.NUM_CLASSES(10), .DATA_W(8), .SIGNED(0), .ADDR_W(10), .RD_LATENCY(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  argmax_unit #(.NUM_CLASSES(16), .DATA_W(8), .SIGNED(1), .ADDR_W(4), .RD_LATENCY(3))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Score RAMs with the matching read latencies.
  logic [7:0] mem_a [1024];
  logic [7:0] mem_b [16];
  logic [7:0] dpa;
  logic [7:0] dpb [3];
  always @(posedge clk) begin
    dpa    <= mem_a[ifa.rd_addr];
    dpb[0] <= mem_b[ifb.rd_addr];
    dpb[1] <= dpb[0];
    dpb[2] <= dpb[1];
  end
  assign ifa.rd_data = dpa;
  assign ifb.rd_data = dpb[2];

  // View of whichever instance is under test.
  bit sel_b = 1'b0;
  logic [31:0] v_en, v_addr, v_busy, v_done, v_cat, v_max, v_sec, v_mg;
  assign v_en   = sel_b ? 32'(ifb.rd_en)        : 32'(ifa.rd_en);
  assign v_addr = sel_b ? 32'(ifb.rd_addr)      : 32'(ifa.rd_addr);
  assign v_busy = sel_b ? 32'(ifb.busy)         : 32'(ifa.busy);
  assign v_done = sel_b ? 32'(ifb.done)         : 32'(ifa.done);
  assign v_cat  = sel_b ? 32'(ifb.category_out) : 32'(ifa.category_out);
  assign v_max  = sel_b ? 32'(ifb.max_score)    : 32'(ifa.max_score);
  assign v_sec  = sel_b ? 32'(ifb.second_idx)   : 32'(ifa.second_idx);
  assign v_mg   = sel_b ? 32'(ifb.margin)       : 32'(ifa.margin);

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Winner = largest value, first occurrence; runner-up = largest of the rest, first occurrence.
  function automatic void ref_model(input int sc[$], output int bi, output int bv,
                                    output int si, output int mg);
    int sv;
    bi = 0;
    bv = sc[0];
    for (int i = 1; i < sc.size(); i++)
      if (sc[i] > bv) begin bv = sc[i]; bi = i; end
    si = -1;
    sv = 0;
    for (int i = 0; i < sc.size(); i++)
      if (i != bi && (si < 0 || sc[i] > sv)) begin sv = sc[i]; si = i; end
    mg = bv - sv;
  endfunction

  task automatic load(input bit sel, input int base, input int sc[$]);
    int t;
    for (int i = 0; i < sc.size(); i++) begin
      t = sc[i];
      if (sel) mem_b[(base + i) % 16]   = t[7:0];
      else     mem_a[(base + i) % 1024] = t[7:0];
    end
  endtask

  function automatic logic [31:0] outs_or();
    return v_en | v_addr | v_busy | v_done | v_cat | v_max | v_sec | v_mg;
  endfunction

  task automatic check_result(input string tag, input int sc[$]);
    int bi, bv, si, mg;
    ref_model(sc, bi, bv, si, mg);
    chk({tag, "_cat"}, v_cat, 32'(bi));
    chk({tag, "_max"}, v_max, 32'(bv & 255));
`ifdef ARGMAX_MARGIN_EN
    chk({tag, "_sec"}, v_sec, 32'(si));
    chk({tag, "_margin"}, v_mg, 32'(mg & 511));
`else
    chk({tag, "_sec"}, v_sec, 32'(0));
    chk({tag, "_margin"}, v_mg, 32'(0));
`endif
  endtask

  // One request: checks read sequence, busy, latency, results and the done pulse width.
  task automatic do_run(input bit sel, input int base, input int sc[$], input string tag);
    int n, lat, amod, errs, done_cyc;
    n = sel ? 16 : 10;
    lat = sel ? 3 : 1;
    amod = sel ? 16 : 1024;
    sel_b = sel;
    load(sel, base, sc);
    errs = 0;
    done_cyc = 0;
    @(negedge clk);
    if (sel) begin ifb.start = 1'b1; ifb.base_addr = 4'(base); end
    else     begin ifa.start = 1'b1; ifa.base_addr = 10'(base); end
    for (int c = 1; c <= n + lat + 10; c++) begin
      @(negedge clk);
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      if (v_en !== 32'(c <= n)) errs++;
      else if (c <= n && v_addr !== 32'((base + c - 1) % amod)) errs++;
      if (v_busy !== 32'd1) errs++;
      if (v_done === 32'd1) begin done_cyc = c; break; end
    end
    chk({tag, "_latency"}, 32'(done_cyc), 32'(n + lat + 2));
    chk({tag, "_rdseq_errs"}, 32'(errs), 32'd0);
    check_result(tag, sc);
    @(negedge clk);
    chk({tag, "_post_done_busy"}, v_done | v_busy, 32'd0);
    chk({tag, "_hold_max"}, v_max, 32'(sc[v_cat] & 255));
  endtask

  initial begin
    int sc[$];
    int d1, d2, en_cnt, bad;
    rst = 1'b1;
    ifa.start = 1'b0; ifa.base_addr = '0;
    ifb.start = 1'b0; ifb.base_addr = '0;
    for (int i = 0; i < 1024; i++) mem_a[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem_b[i] = 8'h00;
    repeat (3) @(negedge clk);
    sel_b = 1'b0; #1;
    chk("reset_a_outputs", outs_or(), 32'd0);
    sel_b = 1'b1; #1;
    chk("reset_b_outputs", outs_or(), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed unsigned cases.
    sc = '{3, 9, 2, 7, 1, 0, 4, 8, 5, 6};
    do_run(1'b0, 0, sc, "a_basic");
    sc = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    do_run(1'b0, 512, sc, "a_tie");

    // Randomised unsigned cases, one straddling the top of the address space.
    for (int r = 0; r < 3; r++) begin
      sc.delete();
      for (int i = 0; i < 10; i++) sc.push_back(int'($urandom_range(0, 255)));
      do_run(1'b0, (r == 0) ? 1020 : int'($urandom_range(0, 1023)), sc, "a_rand");
    end

    // Signed scores.
    sc = '{-128, -3, -50, -100, -100, -100, -100, -100,
           -100, -100, -100, -100, -100, -100, -100, -100};
    do_run(1'b1, 0, sc, "b_signed");

    // Wrapping address with the winner in the last class.
    sc.delete();
    for (int i = 0; i < 15; i++) sc.push_back(int'($urandom_range(0, 254)) - 128);
    sc.push_back(127);
    do_run(1'b1, 14, sc, "b_wrap");

    for (int r = 0; r < 2; r++) begin
      sc.delete();
      for (int i = 0; i < 16; i++) sc.push_back(int'($urandom_range(0, 255)) - 128);
      do_run(1'b1, int'($urandom_range(0, 15)), sc, "b_rand");
    end

    // start held high: re-accepted only after each done, no extra reads.
    sel_b = 1'b0;
    sc.delete();
    for (int i = 0; i < 10; i++) sc.push_back(int'($urandom_range(0, 255)));
    load(1'b0, 40, sc);
    d1 = 0; d2 = 0; en_cnt = 0;
    @(negedge clk);
    ifa.start = 1'b1;
    ifa.base_addr = 10'd40;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (v_en === 32'd1) en_cnt++;
      if (v_done === 32'd1) begin
        if (d1 == 0) d1 = c;
        else begin d2 = c; ifa.start = 1'b0; break; end
      end
    end
    chk("hold_first_done", 32'(d1), 32'd13);
    chk("hold_second_done", 32'(d2), 32'd27);
    chk("hold_read_count", 32'(en_cnt), 32'd20);
    check_result("hold", sc);
    @(negedge clk);
    chk("hold_idle_busy", v_busy, 32'd0);

    // Reset mid-read: run aborts, outputs clear, no stale done.
    sc.delete();
    for (int i = 0; i < 10; i++) sc.push_back(int'($urandom_range(1, 255)));
    load(1'b0, 200, sc);
    @(negedge clk);
    ifa.start = 1'b1;
    ifa.base_addr = 10'd200;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      ifa.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    sel_b = 1'b0; #1;
    chk("midrst_a_outputs", outs_or(), 32'd0);
    sel_b = 1'b1; #1;
    chk("midrst_b_outputs", outs_or(), 32'd0);
    sel_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (v_done !== 32'd0 || v_en !== 32'd0 || v_busy !== 32'd0) bad++;
    end
    chk("midrst_quiet_cycles", 32'(bad), 32'd0);
    sc = '{10, 20, 30, 40, 250, 60, 70, 80, 90, 100};
    do_run(1'b0, 200, sc, "after_rst");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/argmax_unit.md
# argmax_unit

Parametrised argmax stage at the tail of the CNN pipeline, successor to the single-purpose 10-class decision block. Streams NUM_CLASSES scores from the final-layer score RAM at one read per cycle with a configurable read latency. Returns the winning class index and its score. A compile-time option adds the runner-up class and the winner–runner-up margin as a confidence measure.

## Interface
- NUM_CLASSES, 10: number of scores read; must be ≥ 2.
- DATA_W, 8: score width.
- SIGNED, 0: 1 = scores are two's complement; 0 = unsigned.
- ADDR_W, 10: RAM address width.
- RD_LATENCY, 1: cycles from rd_addr/rd_en to valid rd_data; must be ≥ 1.
- IDX_W, $clog2(NUM_CLASSES): class index width (derived, not overridden).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- base_addr  in  ADDR_W  address of class 0; captured on accepted start.
- rd_en  out  1  read strobe.
- rd_addr  out  ADDR_W  read address.
- rd_data  in  DATA_W  score returned RD_LATENCY cycles after rd_en.
- busy  out  1  high from accepted start through the done cycle.
- done  out  1  one-cycle pulse; results valid from this cycle.
- category_out  out  IDX_W  winning index.
- max_score  out  DATA_W  winning score.
- second_idx  out  IDX_W  runner-up index (MARGIN build only).
- margin  out  DATA_W+1  max_score − second score, unsigned (MARGIN build only).

## Operation
- The FSM has four states: IDLE, ISSUE, DRAIN and DONE.
- IDLE → ISSUE on start. Capture base_addr, clear the issue counter, clear the compare counter and set busy.
- ISSUE: drive rd_en=1 and rd_addr = base_addr + i, with i = 0..NUM_CLASSES−1, one per cycle. The addition wraps modulo 2^ADDR_W. After i = NUM_CLASSES−1, go to DRAIN.
- Read tracking: a RD_LATENCY-deep valid/index shift register tracks reads in flight. When an entry exits with valid set, rd_data is compared against the current best for that index.
- Compare on the first element (k = 0): load best unconditionally.
- Compare on later elements: update only when rd_data > best, a strict compare. Ties keep the lower index.
- Signedness: SIGNED selects signed or unsigned comparison and margin arithmetic.
- DRAIN: rd_en=0. Wait until the last element (k = NUM_CLASSES−1) is compared, then go to DONE.
- DONE: register category_out and max_score, plus second_idx and margin when enabled. Pulse done, then go to IDLE and clear busy in the same transition.
- Outputs hold their values until the next done or reset.
- start while busy is ignored; there is no queueing.
- rst at any time, including mid-read, returns to IDLE. Reset clears the pipeline valids, so no stale return data is compared afterwards.
- Reset values: rd_en, rd_addr, busy, done, category_out, max_score, second_idx and margin are all 0.

## Timing
- Cycle 0: start sampled high in IDLE.
- Cycles 1..N: rd_en high, with rd_addr = base+0 .. base+N−1 (N = NUM_CLASSES).
- Compare: element k is compared in cycle 1+k+RD_LATENCY.
- Result: done high in cycle N+RD_LATENCY+2, together with valid outputs.
- Total latency from start to done is N+RD_LATENCY+2 cycles; for the defaults this is 13.
- Back-to-back: start is accepted in the cycle after done, so the issue rate is one request per N+RD_LATENCY+3 cycles.
- rd_data is only sampled in compare cycles; its value is don't-care otherwise.

## Configuration
- ARGMAX_MARGIN_EN defined: a runner-up tracker is compiled in.
  - k = 0: best is loaded and second is invalid.
  - rd_data > best: second ← best and best ← new.
  - Otherwise, if second is invalid or rd_data > second: second ← new. This includes a tie with best, so an equal score becomes the runner-up.
  - margin = best − second, zero-extended (unsigned) or computed at DATA_W+1 (signed), so it never overflows.
- ARGMAX_MARGIN_EN undefined: second_idx and margin are tied to 0 and no runner-up logic exists. Argmax behaviour and timing are identical in both builds.

## Test plan
- Defaults, base 0, scores {3,9,2,7,1,0,4,8,5,6}: done at cycle 13, category_out=1, max_score=9. MARGIN build: second_idx=7, margin=1.
- Tie {5,5,5,5,5,5,5,5,5,5}: category_out=0. MARGIN build: second_idx=1, margin=0.
- SIGNED=1, DATA_W=8, scores {−128,−3,−50,…,−100}: category_out=1, max_score=−3 (0xFD). MARGIN build: margin equals −3 minus the runner-up score.
- NUM_CLASSES=16, RD_LATENCY=3, ADDR_W=4, base_addr=14, max at class 15: rd_addr sequence 14,15,0,…,13; category_out=15; done 21 cycles after start.
- rst asserted in cycle 5 of a run, then a new start with different data: the first run produces no done, all outputs are 0, and the second run's result matches the new data only.
- start held high continuously: start is re-accepted the cycle after each done, and start pulses during busy produce no extra reads.
